alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//   Result buffer that sits directly downstream of the 8-bit ALU. It captures
//   each 9-bit ALU result together with its 3-bit op select and derives status
//   flags at capture time. Captured entries are held in a small circular FIFO
//   and drained by the consumer through a valid/ready handshake, so that ALU
//   results are not lost while the consumer stalls.
// PARAMETERS
//   DATA_W  9  result width (ALU carry/borrow bit + 8-bit value)
//   SEL_W   3  op-select width stored alongside each result
//   DEPTH   4  FIFO entries; must be a power of 2 and >= 2
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   clr         in   1           synchronous flush; empties FIFO, clears drop_err
//   in_valid    in   1           push request; result/sel are valid this cycle
//   in_ready    out  1           FIFO can accept a push (= !full)
//   in_result   in   DATA_W      ALU result
//   in_sel      in   SEL_W       ALU op select for this result
//   out_valid   out  1           head entry is valid (= !empty)
//   out_ready   in   1           consumer pops the head entry this cycle
//   out_result  out  DATA_W      head entry result
//   out_sel     out  SEL_W       head entry op select
//   out_zero    out  1           head flag: result[7:0] == 0
//   out_carry   out  1           head flag: result[8] (carry for ADD/INC, borrow for SUB/DEC)
//   out_neg     out  1           head flag: result[7]
//   count       out  log2(DEPTH)+1  number of entries held, 0..DEPTH
//   drop_err    out  1           sticky: a push was attempted while full
// BEHAVIOUR
// - Reset (rst_n=0, async): pointers=0, count=0, out_valid=0, in_ready=1,
//   drop_err=0, and storage cleared so that out_result/out_sel/flags read 0.
//   Reset asserted mid-operation discards all entries immediately, without
//   waiting for a clock edge.
// - Push: accepted when in_valid && in_ready. The entry {flags, sel, result}
//   is written at wr_ptr and wr_ptr is incremented modulo DEPTH. Flags are
//   computed from in_result at write time and stored; they are not recomputed
//   at read.
// - Pop: occurs when out_valid && out_ready. rd_ptr is incremented modulo DEPTH.
// - Read mode is first-word fall-through. out_* always reflects mem[rd_ptr],
//   so a pushed entry appears on out_* the cycle after the push edge
//   (1-cycle latency).
// - Empty FIFO: out_valid=0. out_* then holds the stale contents of mem[rd_ptr];
//   the consumer must ignore it. A pop request while empty is ignored.
// - Full FIFO (count=DEPTH): in_ready=0. A push attempted while full is dropped,
//   FIFO state is unchanged, and drop_err is set on the next edge. drop_err stays
//   set until clr or reset.
// - Simultaneous push and pop:
//   - 0 < count < DEPTH: both are performed and count is unchanged.
//   - count=0: only the push is performed (no pass-through).
//   - count=DEPTH: only the pop is performed, because in_ready=0; the push is
//     dropped and drop_err is set.
// - Priority: clr > push/pop. A cycle with clr=1 ends with pointers=0, count=0
//   and drop_err=0, and any push or pop in that cycle is discarded.
// - count, in_ready and out_valid are registered-state derived. There is no
//   combinational path from in_valid to out_valid, or from out_ready to in_ready.
// TESTING
//   1) Assert reset, then release it -> out_valid=0, in_ready=1, count=0,
//      drop_err=0.
//   2) Push in_result=0x176, in_sel=3'b010 (0xAA+0xCC) -> next cycle out_valid=1,
//      out_result=0x176, carry=1, neg=0, zero=0, count=1.
//   3) Hold out_ready=0 and push 0x088, 0x0EE, 0x1DE, 0x066 -> count=4,
//      in_ready=0. A fifth push of 0x0AB is dropped and drop_err=1. Pops then
//      return 0x088, 0x0EE, 0x1DE (neg=1, carry=1), 0x066, in that order.
//   4) Hold count=2 and push+pop every cycle for 10 cycles -> count stays 2,
//      data stays in order across pointer wrap, and drop_err stays 0.
//   5) Push 0x100 -> zero=1, carry=1, neg=0. Push 0x000 -> zero=1, carry=0.
//   6) With count=3, pulse rst_n low between clock edges -> count=0 and
//      out_valid=0 immediately. Repeat with clr=1 together with push+pop ->
//      count=0 and drop_err=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: circular result buffer downstream of the 8-bit ALU.
// Captures {flags, sel, result} on push and exposes the head entry
// first-word fall-through, drained by a valid/ready consumer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr                   sync flush (pointers, count, drop_err)
//   in_valid/in_ready     push handshake (in_ready = !full)
//   in_result, in_sel     ALU result and op select to capture
//   out_valid/out_ready   pop handshake (out_valid = !empty)
//   out_result, out_sel   head entry contents
//   out_zero/carry/neg    head flags, stored at capture time
//   count                 entries held, 0..DEPTH
//   drop_err              sticky: push attempted while full
module alu_result_fifo #(
    parameter int DATA_W = 9,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [SEL_W-1:0]         in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_zero,
    output logic                     out_carry,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [SEL_W-1:0]  mem_sel    [DEPTH];
    // {zero, carry, neg}
    logic [2:0]        mem_flags  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [2:0]    in_flags;

    // Handshake flags come only from registered count, so there is
    // no path from in_valid to out_valid or out_ready to in_ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Top bit is carry/borrow; the one below is the 8-bit sign.
    assign in_flags = {
        (in_result[DATA_W-2:0] == '0),
        in_result[DATA_W-1],
        in_result[DATA_W-2]
    };

    assign out_result = mem_result[rd_ptr];
    assign out_sel    = mem_sel[rd_ptr];
    assign out_zero   = mem_flags[rd_ptr][2];
    assign out_carry  = mem_flags[rd_ptr][1];
    assign out_neg    = mem_flags[rd_ptr][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_sel[i]    <= '0;
                mem_flags[i]  <= '0;
            end
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= in_result;
                mem_sel[wr_ptr]    <= in_sel;
                mem_flags[wr_ptr]  <= in_flags;
                wr_ptr             <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed self-checking bench for alu_result_fifo.
// Inputs change after the falling edge; outputs are sampled there too.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_result;
    logic [2:0] in_sel;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_result;
    logic [2:0] out_sel;
    logic       out_zero;
    logic       out_carry;
    logic       out_neg;
    logic [2:0] count;
    logic       drop_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_neg    (out_neg),
        .count      (count),
        .drop_err   (drop_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] r, input logic [2:0] s);
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = r;
        in_sel    = s;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic [8:0] q[$];
    logic [8:0] exp_data[4];
    logic [8:0] nxt;

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_sel    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_sel", out_sel, 0);

        // 2) single push 0xAA+0xCC
        push(9'h176, 3'b010);
        check("p1_out_valid", out_valid, 1);
        check("p1_result", out_result, 9'h176);
        check("p1_sel", out_sel, 3'b010);
        check("p1_carry", out_carry, 1);
        check("p1_neg", out_neg, 0);
        check("p1_zero", out_zero, 0);
        check("p1_count", count, 1);
        pop1();
        check("p1_drain_count", count, 0);
        check("p1_drain_valid", out_valid, 0);

        // 3) fill, overflow, drain in order
        exp_data[0] = 9'h088;
        exp_data[1] = 9'h0EE;
        exp_data[2] = 9'h1DE;
        exp_data[3] = 9'h066;
        for (int i = 0; i < 4; i++) push(exp_data[i], 3'(i));
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_drop_pre", drop_err, 0);
        push(9'h0AB, 3'b111);
        check("ovf_drop_err", drop_err, 1);
        check("ovf_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_result", i), out_result, exp_data[i]);
            check($sformatf("drain%0d_sel", i), out_sel, i);
            if (i == 2) begin
                check("drain2_neg", out_neg, 1);
                check("drain2_carry", out_carry, 1);
            end
            pop1();
        end
        check("drain_count", count, 0);
        check("drain_drop_sticky", drop_err, 1);
        do_clr();
        check("clr_drop_err", drop_err, 0);

        // push+pop at count=0: push only
        @(negedge clk);
        in_valid  = 1'b1;
        in_result = 9'h011;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_empty_count", count, 1);
        check("pp_empty_result", out_result, 9'h011);

        // 4) steady push+pop at count=2 across wrap
        push(9'h022, 3'b001);
        q = '{9'h011, 9'h022};
        check("ss_count0", count, 2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("ss%0d_head", i), out_result, q[0]);
            nxt       = 9'h030 + 9'(i);
            in_valid  = 1'b1;
            in_result = nxt;
            out_ready = 1'b1;
            q.push_back(nxt);
            void'(q.pop_front());
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("ss_count", count, 2);
        check("ss_drop_err", drop_err, 0);
        check("ss_tail0", out_result, q[0]);
        pop1();
        check("ss_tail1", out_result, q[1]);
        pop1();
        check("ss_empty", out_valid, 0);

        // 5) flag boundaries
        push(9'h100, 3'b000);
        check("z100_zero", out_zero, 1);
        check("z100_carry", out_carry, 1);
        check("z100_neg", out_neg, 0);
        pop1();
        push(9'h000, 3'b000);
        check("z000_zero", out_zero, 1);
        check("z000_carry", out_carry, 0);
        check("z000_neg", out_neg, 0);
        pop1();

        // 6) async reset mid-operation
        for (int i = 0; i < 3; i++) push(9'h041 + 9'(i), 3'b011);
        check("r6_count_pre", count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("r6_count", count, 0);
        check("r6_out_valid", out_valid, 0);
        check("r6_in_ready", in_ready, 1);
        check("r6_result", out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // clr beats push+pop, also clearing drop_err
        for (int i = 0; i < 5; i++) push(9'h050 + 9'(i), 3'b100);
        check("c6_count_full", count, 4);
        check("c6_drop_pre", drop_err, 1);
        @(negedge clk);
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_result = 9'h055;
        out_ready = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("c6_count", count, 0);
        check("c6_drop_err", drop_err, 0);
        check("c6_out_valid", out_valid, 0);
        push(9'h0C3, 3'b101);
        check("c6_after_head", out_result, 9'h0C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
